i2c_master_xfer_seq: RTL and testbench
======================================

Name: i2c_master_xfer_seq

Overview:
Transaction sequencer directly upstream of the I2C byte controller.
- Accepts one register-style request: 7-bit device address, 8-bit register address, direction, byte count.
- Expands the request into the byte-level command sequence (start, write, read, ack, stop) and drives the byte controller.
- Streams write data in and read data out, and reports one completion status per request to the APB register block.

Parameters:
LEN_W, 4, width of the byte-count field; legal counts are 1..2^LEN_W-1.

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  sequencer idle; request accepted when req_valid & req_ready
req_rnw  input  1  1 = register read, 0 = register write
req_dev  input  7  7-bit slave address
req_reg  input  8  register address
req_len  input  LEN_W  number of data bytes
wdata_valid  input  1  write byte available
wdata  input  8  write byte
wdata_ready  output  1  one-cycle pulse: wdata consumed
rdata_valid  output  1  one-cycle pulse: read byte valid (no backpressure)
rdata  output  8  read byte
cmpl_valid  output  1  one-cycle pulse: request finished
cmpl_status  output  2  00 OK, 01 NACK, 10 arbitration lost, 11 bad length
bc_start, bc_stop, bc_read, bc_write  output  1 each  byte-controller commands
bc_ack_in  output  1  ack to drive after a read byte (1 = NACK)
bc_din  output  8  byte to transmit
bc_done  input  1  byte-controller done pulse
bc_ack_out  input  1  received ack (1 = NACK)
bc_dout  input  8  received byte
bc_al  input  1  arbitration lost

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. Request fields are registered on accept.
- Command outputs are registered and held stable until the cycle bc_done is seen. The next command is presented on the following cycle; command bits are never changed mid-byte.
- States: IDLE, DEV_W, REG, DATA_W, DEV_R, DATA_R, STOP_ONLY, CMPL.
- IDLE, on accept:
  - req_len == 0: go to CMPL with status 11; no bus command is issued.
  - Otherwise go to DEV_W with bc_start = 1, bc_write = 1, bc_din = {req_dev, 0}.
- DEV_W, on done:
  - bc_ack_out = 1: go to STOP_ONLY with status 01.
  - Otherwise go to REG with bc_write = 1, bc_din = req_reg.
- REG, on done with ACK:
  - Write request: go to DATA_W.
  - Read request: go to DEV_R with bc_start = 1 (repeated start), bc_write = 1, bc_din = {req_dev, 1}.
  - On NACK: go to STOP_ONLY with status 01.
- DATA_W:
  - Commands are idle while wdata_valid = 0.
  - On wdata_valid: capture wdata into bc_din, pulse wdata_ready, assert bc_write. Assert bc_stop as well when this is the last byte (remaining == 1).
  - On done: NACK on a non-last byte goes to STOP_ONLY with status 01. The last byte goes to CMPL with status 01 if NACK, 00 if ACK; its stop was already issued.
- DEV_R, on done:
  - NACK: go to STOP_ONLY with status 01.
  - ACK: go to DATA_R.
- DATA_R:
  - Assert bc_read. bc_ack_in = 0 except on the last byte, where bc_ack_in = 1 and bc_stop = 1.
  - Each done: rdata = bc_dout and rdata_valid pulses that cycle. The last byte goes to CMPL with status 00.
- STOP_ONLY: bc_stop = 1 alone; on done go to CMPL.
- CMPL: pulse cmpl_valid for one cycle with the latched status, then go to IDLE, where req_ready = 1 again.
- Remaining counter: loaded with req_len on accept; decremented on each data-byte done. It never wraps.
- bc_al, in any non-IDLE state:
  - All bc_* commands drop to 0 the next cycle, no stop is issued, and the FSM goes to CMPL with status 10.
  - bc_al has priority over a simultaneous bc_done.
  - Read bytes delivered before the loss remain valid.
- bc_done while in IDLE or CMPL is ignored.
- Asynchronous reset mid-transfer returns to the reset values immediately; no stop is generated.

Test Plan:
- Write dev=0x50, reg=0x10, len=2, data 0xA5, 0x5A, all ACK -> bc_din sequence 0xA0, 0x10, 0xA5, 0x5A. Start only on the first byte, stop only on the last. Two wdata_ready pulses; cmpl_status = 00.
- Read dev=0x50, reg=0x20, len=3; slave returns 0x11, 0x22, 0x33 -> bc_din sequence 0xA0, 0x20, 0xA1 with a repeated start on 0xA1. Three rdata_valid pulses with 0x11, 0x22, 0x33; bc_ack_in = 1 only on the third byte; status 00.
- Address NACK: bc_ack_out = 1 on the first byte -> stop-only command issued, status 01, no wdata_ready pulse.
- Arbitration loss asserted during REG simultaneously with bc_done -> commands cleared next cycle, no stop, status 10, req_ready = 1 two cycles later.
- req_len = 0 -> cmpl_valid two cycles after accept with status 11; no bc_* command asserted.
- Write len=1 with wdata_valid delayed 20 cycles -> no bc_write until the data arrives; then a single byte is sent with write and stop together.

Source files
------------

// File: rtl/i2c_master_xfer_seq.sv
// i2c_master_xfer_seq
// Register-style I2C transaction sequencer. Turns one {dev, reg, rnw, len}
// request into the byte-level command stream for the I2C byte controller,
// moves write/read data bytes, and reports one completion status per request.
module i2c_master_xfer_seq #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rnw,
  input  logic [6:0]       req_dev,
  input  logic [7:0]       req_reg,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wdata_valid,
  input  logic [7:0]       wdata,
  output logic             wdata_ready,
  output logic             rdata_valid,
  output logic [7:0]       rdata,
  output logic             cmpl_valid,
  output logic [1:0]       cmpl_status,
  output logic             bc_start,
  output logic             bc_stop,
  output logic             bc_read,
  output logic             bc_write,
  output logic             bc_ack_in,
  output logic [7:0]       bc_din,
  input  logic             bc_done,
  input  logic             bc_ack_out,
  input  logic [7:0]       bc_dout,
  input  logic             bc_al
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEV_W     = 3'd1,
    REG       = 3'd2,
    DATA_W    = 3'd3,
    DEV_R     = 3'd4,
    DATA_R    = 3'd5,
    STOP_ONLY = 3'd6,
    CMPL      = 3'd7
  } state_t;

  // Command vector layout: {start, stop, read, write, ack_in}
  localparam logic [4:0] CMD_NONE     = 5'b00000;
  localparam logic [4:0] CMD_START_WR = 5'b10010;
  localparam logic [4:0] CMD_WR       = 5'b00010;
  localparam logic [4:0] CMD_WR_STOP  = 5'b01010;
  localparam logic [4:0] CMD_STOP     = 5'b01000;
  localparam logic [4:0] CMD_RD       = 5'b00100;
  localparam logic [4:0] CMD_RD_LAST  = 5'b01101;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_NACK = 2'b01;
  localparam logic [1:0] ST_AL   = 2'b10;
  localparam logic [1:0] ST_LEN  = 2'b11;

  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_TWO  = LEN_W'(2);

  state_t           state_r, state_s;
  logic             rnw_r, rnw_s;
  logic [6:0]       dev_r, dev_s;
  logic [7:0]       reg_r, reg_s;
  logic [LEN_W-1:0] rem_r, rem_s;
  logic [1:0]       status_r, status_s;
  logic             req_ready_r, req_ready_s;
  logic             wdata_ready_r, wdata_ready_s;
  logic             rdata_valid_r, rdata_valid_s;
  logic [7:0]       rdata_r, rdata_s;
  logic             cmpl_valid_r, cmpl_valid_s;
  logic [1:0]       cmpl_status_r, cmpl_status_s;
  logic [4:0]       cmd_r, cmd_s;
  logic [7:0]       din_r, din_s;
  logic             last_s;
  logic             bus_busy_s;
  logic [LEN_W-1:0] rem_dec_s;

  assign req_ready   = req_ready_r;
  assign wdata_ready = wdata_ready_r;
  assign rdata_valid = rdata_valid_r;
  assign rdata       = rdata_r;
  assign cmpl_valid  = cmpl_valid_r;
  assign cmpl_status = cmpl_status_r;
  assign bc_start    = cmd_r[4];
  assign bc_stop     = cmd_r[3];
  assign bc_read     = cmd_r[2];
  assign bc_write    = cmd_r[1];
  assign bc_ack_in   = cmd_r[0];
  assign bc_din      = din_r;

  // Next-state, next-command and next-output computation for the sequencer
  always_comb begin
    state_s       = state_r;
    rnw_s         = rnw_r;
    dev_s         = dev_r;
    reg_s         = reg_r;
    rem_s         = rem_r;
    status_s      = status_r;
    wdata_ready_s = 1'b0;
    rdata_valid_s = 1'b0;
    rdata_s       = rdata_r;
    cmpl_valid_s  = 1'b0;
    cmpl_status_s = cmpl_status_r;
    cmd_s         = cmd_r;
    din_s         = din_r;
    last_s        = (rem_r == LEN_ONE);
    bus_busy_s    = (state_r != IDLE) && (state_r != CMPL);
    rem_dec_s     = (rem_r != LEN_ZERO) ? (rem_r - LEN_ONE) : rem_r;

    if (bus_busy_s && bc_al) begin
      // Lost the bus: release everything, no stop, report arbitration loss.
      cmd_s    = CMD_NONE;
      status_s = ST_AL;
      state_s  = CMPL;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            rnw_s = req_rnw;
            dev_s = req_dev;
            reg_s = req_reg;
            rem_s = req_len;
            if (req_len == LEN_ZERO) begin
              status_s = ST_LEN;
              state_s  = CMPL;
            end else begin
              cmd_s   = CMD_START_WR;
              din_s   = {req_dev, 1'b0};
              state_s = DEV_W;
            end
          end else begin
            state_s = IDLE;
          end
        end
        DEV_W: begin
          if (bc_done) begin
            if (bc_ack_out) begin
              cmd_s    = CMD_STOP;
              status_s = ST_NACK;
              state_s  = STOP_ONLY;
            end else begin
              cmd_s   = CMD_WR;
              din_s   = reg_r;
              state_s = REG;
            end
          end else begin
            cmd_s = cmd_r;
          end
        end
        REG: begin
          if (bc_done) begin
            if (bc_ack_out) begin
              cmd_s    = CMD_STOP;
              status_s = ST_NACK;
              state_s  = STOP_ONLY;
            end else if (rnw_r) begin
              // Repeated start with the read address
              cmd_s   = CMD_START_WR;
              din_s   = {dev_r, 1'b1};
              state_s = DEV_R;
            end else begin
              cmd_s   = CMD_NONE;
              state_s = DATA_W;
            end
          end else begin
            cmd_s = cmd_r;
          end
        end
        DATA_W: begin
          if (cmd_r[1]) begin
            // A byte is on the wire; wait for it to finish.
            if (bc_done) begin
              rem_s = rem_dec_s;
              if (last_s) begin
                // Stop went out together with this byte.
                cmd_s    = CMD_NONE;
                status_s = bc_ack_out ? ST_NACK : ST_OK;
                state_s  = CMPL;
              end else if (bc_ack_out) begin
                cmd_s    = CMD_STOP;
                status_s = ST_NACK;
                state_s  = STOP_ONLY;
              end else begin
                cmd_s = CMD_NONE;
              end
            end else begin
              cmd_s = cmd_r;
            end
          end else if (wdata_valid) begin
            din_s         = wdata;
            wdata_ready_s = 1'b1;
            cmd_s         = last_s ? CMD_WR_STOP : CMD_WR;
          end else begin
            cmd_s = CMD_NONE;
          end
        end
        DEV_R: begin
          if (bc_done) begin
            if (bc_ack_out) begin
              cmd_s    = CMD_STOP;
              status_s = ST_NACK;
              state_s  = STOP_ONLY;
            end else begin
              cmd_s   = last_s ? CMD_RD_LAST : CMD_RD;
              state_s = DATA_R;
            end
          end else begin
            cmd_s = cmd_r;
          end
        end
        DATA_R: begin
          if (bc_done) begin
            rdata_s       = bc_dout;
            rdata_valid_s = 1'b1;
            rem_s         = rem_dec_s;
            if (last_s) begin
              cmd_s    = CMD_NONE;
              status_s = ST_OK;
              state_s  = CMPL;
            end else begin
              // The byte after this one is the last: NACK it and stop.
              cmd_s = (rem_r == LEN_TWO) ? CMD_RD_LAST : CMD_RD;
            end
          end else begin
            cmd_s = cmd_r;
          end
        end
        STOP_ONLY: begin
          if (bc_done) begin
            cmd_s   = CMD_NONE;
            state_s = CMPL;
          end else begin
            cmd_s = cmd_r;
          end
        end
        CMPL: begin
          cmpl_valid_s  = 1'b1;
          cmpl_status_s = status_r;
          cmd_s         = CMD_NONE;
          state_s       = IDLE;
        end
        default: begin
          cmd_s   = CMD_NONE;
          state_s = IDLE;
        end
      endcase
    end

    req_ready_s = (state_s == IDLE);
  end

  // State, request fields and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= IDLE;
      rnw_r         <= 1'b0;
      dev_r         <= 7'd0;
      reg_r         <= 8'd0;
      rem_r         <= LEN_ZERO;
      status_r      <= 2'b00;
      req_ready_r   <= 1'b1;
      wdata_ready_r <= 1'b0;
      rdata_valid_r <= 1'b0;
      rdata_r       <= 8'd0;
      cmpl_valid_r  <= 1'b0;
      cmpl_status_r <= 2'b00;
      cmd_r         <= CMD_NONE;
      din_r         <= 8'd0;
    end else begin
      state_r       <= state_s;
      rnw_r         <= rnw_s;
      dev_r         <= dev_s;
      reg_r         <= reg_s;
      rem_r         <= rem_s;
      status_r      <= status_s;
      req_ready_r   <= req_ready_s;
      wdata_ready_r <= wdata_ready_s;
      rdata_valid_r <= rdata_valid_s;
      rdata_r       <= rdata_s;
      cmpl_valid_r  <= cmpl_valid_s;
      cmpl_status_r <= cmpl_status_s;
      cmd_r         <= cmd_s;
      din_r         <= din_s;
    end
  end

endmodule

// File: tb/tb_i2c_master_xfer_seq.sv
// Directed bench for i2c_master_xfer_seq. The bench plays the byte controller,
// keeps scoreboards of expected commands, read bytes and completion statuses,
// and compares as the sequencer produces them.
module tb_i2c_master_xfer_seq;

  localparam int LEN_W = 4;

  // Command vector layout: {start, stop, read, write, ack_in}
  localparam logic [4:0] C_START_WR = 5'b10010;
  localparam logic [4:0] C_WR       = 5'b00010;
  localparam logic [4:0] C_WR_STOP  = 5'b01010;
  localparam logic [4:0] C_STOP     = 5'b01000;
  localparam logic [4:0] C_RD       = 5'b00100;
  localparam logic [4:0] C_RD_LAST  = 5'b01101;

  typedef struct packed {
    logic [4:0] bits;
    logic       chk_din;
    logic [7:0] din;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid;
  logic             req_ready;
  logic             req_rnw;
  logic [6:0]       req_dev;
  logic [7:0]       req_reg;
  logic [LEN_W-1:0] req_len;
  logic             wdata_valid;
  logic [7:0]       wdata;
  logic             wdata_ready;
  logic             rdata_valid;
  logic [7:0]       rdata;
  logic             cmpl_valid;
  logic [1:0]       cmpl_status;
  logic             bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0]       bc_din;
  logic             bc_done;
  logic             bc_ack_out;
  logic [7:0]       bc_dout;
  logic             bc_al;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int cmd_cycles = 0;

  cmd_t       exp_cmd_q[$];
  logic [7:0] exp_rd_q[$];
  logic [1:0] exp_st_q[$];

  i2c_master_xfer_seq #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rnw     (req_rnw),
    .req_dev     (req_dev),
    .req_reg     (req_reg),
    .req_len     (req_len),
    .wdata_valid (wdata_valid),
    .wdata       (wdata),
    .wdata_ready (wdata_ready),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .cmpl_valid  (cmpl_valid),
    .cmpl_status (cmpl_status),
    .bc_start    (bc_start),
    .bc_stop     (bc_stop),
    .bc_read     (bc_read),
    .bc_write    (bc_write),
    .bc_ack_in   (bc_ack_in),
    .bc_din      (bc_din),
    .bc_done     (bc_done),
    .bc_ack_out  (bc_ack_out),
    .bc_dout     (bc_dout),
    .bc_al       (bc_al)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Count wdata_ready pulses and cycles carrying any bus command
  always @(posedge clk) begin
    if (wdata_ready) wr_cnt <= wr_cnt + 1;
    if (bc_start | bc_stop | bc_read | bc_write) cmd_cycles <= cmd_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read-data scoreboard: every rdata_valid pulse pops one expected byte
  always @(negedge clk) begin
    if (rstn === 1'b1 && rdata_valid === 1'b1) begin
      if (exp_rd_q.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
      else check("rdata", 32'(rdata), 32'(exp_rd_q.pop_front()));
    end
  end

  function automatic logic [4:0] cmd_now();
    return {bc_start, bc_stop, bc_read, bc_write, bc_ack_in};
  endfunction

  task automatic push_cmd(input logic [4:0] bits, input logic chk, input logic [7:0] din);
    cmd_t c;
    c.bits    = bits;
    c.chk_din = chk;
    c.din     = din;
    exp_cmd_q.push_back(c);
  endtask

  // Play one byte-controller operation: wait for a command, check it, finish it
  task automatic serve(input logic ack, input logic [7:0] dout, input logic al);
    int   n;
    cmd_t e;
    n = 0;
    while (!(bc_start | bc_stop | bc_read | bc_write) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_present", 32'(n < 50), 32'd1);
    if (wdata_ready) wdata_valid = 1'b0;
    if (exp_cmd_q.size() == 0) begin
      check("cmd_unexpected", 32'd1, 32'd0);
      @(negedge clk);
    end else begin
      e = exp_cmd_q.pop_front();
      check("cmd_bits", 32'(cmd_now()), 32'(e.bits));
      if (e.chk_din) check("cmd_din", 32'(bc_din), 32'(e.din));
      @(negedge clk);
      check("cmd_hold", 32'(cmd_now()), 32'(e.bits));
    end
    bc_done    = 1'b1;
    bc_ack_out = ack;
    bc_dout    = dout;
    bc_al      = al;
    @(negedge clk);
    bc_done    = 1'b0;
    bc_ack_out = 1'b0;
    bc_dout    = 8'h00;
    bc_al      = 1'b0;
  endtask

  task automatic do_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [LEN_W-1:0] len);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_rnw   = rnw;
    req_dev   = dev;
    req_reg   = rg;
    req_len   = len;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for the completion pulse; cyc counts negedges after the accept edge
  task automatic wait_cmpl(output int cyc, output logic rdy);
    cyc = 1;
    while (!cmpl_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    rdy = req_ready;
    check("cmpl_seen", 32'(cmpl_valid), 32'd1);
    if (exp_st_q.size() == 0) check("cmpl_unexpected", 32'd1, 32'd0);
    else check("cmpl_status", 32'(cmpl_status), 32'(exp_st_q.pop_front()));
    @(negedge clk);
    check("cmpl_one_cycle", 32'(cmpl_valid), 32'd0);
  endtask

  initial begin
    int   cyc;
    logic rdy;
    int   w0;
    int   c0;

    rstn        = 1'b0;
    req_valid   = 1'b0;
    req_rnw     = 1'b0;
    req_dev     = 7'h00;
    req_reg     = 8'h00;
    req_len     = 4'd0;
    wdata_valid = 1'b0;
    wdata       = 8'h00;
    bc_done     = 1'b0;
    bc_ack_out  = 1'b0;
    bc_dout     = 8'h00;
    bc_al       = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({req_ready, wdata_ready, rdata_valid, rdata, cmpl_valid, cmpl_status,
                                cmd_now(), bc_din}), 32'({1'b1, 26'd0}));
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", 32'({req_ready, wdata_ready, rdata_valid, rdata, cmpl_valid, cmpl_status,
                                     cmd_now(), bc_din}), 32'({1'b1, 26'd0}));

    // Write dev 0x50 reg 0x10, two bytes, all ACK
    w0 = wr_cnt;
    push_cmd(C_START_WR, 1'b1, 8'hA0);
    push_cmd(C_WR,       1'b1, 8'h10);
    push_cmd(C_WR,       1'b1, 8'hA5);
    push_cmd(C_WR_STOP,  1'b1, 8'h5A);
    exp_st_q.push_back(2'b00);
    do_req(1'b0, 7'h50, 8'h10, 4'd2);
    serve(1'b0, 8'h00, 1'b0);
    serve(1'b0, 8'h00, 1'b0);
    wdata = 8'hA5;
    wdata_valid = 1'b1;
    serve(1'b0, 8'h00, 1'b0);
    wdata = 8'h5A;
    wdata_valid = 1'b1;
    serve(1'b0, 8'h00, 1'b0);
    wait_cmpl(cyc, rdy);
    check("wr2_wdata_ready_pulses", 32'(wr_cnt - w0), 32'd2);

    // Read dev 0x50 reg 0x20, three bytes
    push_cmd(C_START_WR, 1'b1, 8'hA0);
    push_cmd(C_WR,       1'b1, 8'h20);
    push_cmd(C_START_WR, 1'b1, 8'hA1);
    push_cmd(C_RD,       1'b0, 8'h00);
    push_cmd(C_RD,       1'b0, 8'h00);
    push_cmd(C_RD_LAST,  1'b0, 8'h00);
    exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'h22);
    exp_rd_q.push_back(8'h33);
    exp_st_q.push_back(2'b00);
    do_req(1'b1, 7'h50, 8'h20, 4'd3);
    serve(1'b0, 8'h00, 1'b0);
    serve(1'b0, 8'h00, 1'b0);
    serve(1'b0, 8'h00, 1'b0);
    serve(1'b0, 8'h11, 1'b0);
    serve(1'b0, 8'h22, 1'b0);
    serve(1'b0, 8'h33, 1'b0);
    wait_cmpl(cyc, rdy);
    check("rd3_all_bytes_seen", 32'(exp_rd_q.size()), 32'd0);

    // Address NACK with write data already offered
    w0 = wr_cnt;
    push_cmd(C_START_WR, 1'b1, 8'hA0);
    push_cmd(C_STOP,     1'b0, 8'h00);
    exp_st_q.push_back(2'b01);
    wdata = 8'h77;
    wdata_valid = 1'b1;
    do_req(1'b0, 7'h50, 8'h10, 4'd1);
    serve(1'b1, 8'h00, 1'b0);
    serve(1'b0, 8'h00, 1'b0);
    wait_cmpl(cyc, rdy);
    check("nack_no_wdata_ready", 32'(wr_cnt - w0), 32'd0);
    wdata_valid = 1'b0;

    // Arbitration loss together with done during REG
    push_cmd(C_START_WR, 1'b1, 8'hA0);
    push_cmd(C_WR,       1'b1, 8'h30);
    exp_st_q.push_back(2'b10);
    do_req(1'b0, 7'h50, 8'h30, 4'd1);
    serve(1'b0, 8'h00, 1'b0);
    serve(1'b0, 8'h00, 1'b1);
    check("al_cmds_cleared", 32'(cmd_now()), 32'd0);
    check("al_not_ready_yet", 32'(req_ready), 32'd0);
    wait_cmpl(cyc, rdy);
    check("al_cmpl_latency", 32'(cyc), 32'd2);
    check("al_ready_after_two", 32'(rdy), 32'd1);

    // Zero length: immediate completion, no bus activity
    c0 = cmd_cycles;
    exp_st_q.push_back(2'b11);
    do_req(1'b0, 7'h50, 8'h10, 4'd0);
    wait_cmpl(cyc, rdy);
    check("len0_cmpl_latency", 32'(cyc), 32'd2);
    check("len0_no_commands", 32'(cmd_cycles - c0), 32'd0);

    // One-byte write with data arriving 20 cycles late
    w0 = wr_cnt;
    push_cmd(C_START_WR, 1'b1, 8'hA0);
    push_cmd(C_WR,       1'b1, 8'h44);
    push_cmd(C_WR_STOP,  1'b1, 8'hC3);
    exp_st_q.push_back(2'b00);
    do_req(1'b0, 7'h50, 8'h44, 4'd1);
    serve(1'b0, 8'h00, 1'b0);
    serve(1'b0, 8'h00, 1'b0);
    c0 = cmd_cycles;
    repeat (20) @(negedge clk);
    check("late_wdata_idle_cmds", 32'(cmd_cycles - c0), 32'd0);
    wdata = 8'hC3;
    wdata_valid = 1'b1;
    serve(1'b0, 8'h00, 1'b0);
    wait_cmpl(cyc, rdy);
    check("late_wdata_one_pulse", 32'(wr_cnt - w0), 32'd1);

    // Asynchronous reset in the middle of a transfer
    do_req(1'b1, 7'h50, 8'h20, 4'd3);
    check("midreset_cmd_active", 32'(bc_start), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("midreset_outputs", 32'({req_ready, wdata_ready, rdata_valid, rdata, cmpl_valid, cmpl_status,
                                   cmd_now(), bc_din}), 32'({1'b1, 26'd0}));
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_idle", 32'({req_ready, cmd_now()}), 32'({1'b1, 5'd0}));

    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
    check("rdata_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    check("status_queue_drained", 32'(exp_st_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
